sim_clk_seq: RTL and testbench

Run sequencer for the simulation clock. It takes the free-running `clk` from the simulation clock generator and releases DUT reset after a fixed number of cycles. It then produces N divided clock-enable strobes, counts run cycles, and terminates the run cleanly on a cycle limit or a stop request. It sits between the clock generator and the DUT/testbench: the bench pulses `start`, and the block owns reset release, enable cadence and end-of-run signalling.

---
 rtl/sim_clk_seq_pkg.sv | 16 +
 rtl/sim_clk_seq_clk_en_div.sv | 63 ++++++
 rtl/sim_clk_seq.sv | 145 ++++++++++++++
 tb/tb_sim_clk_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sim_clk_seq_pkg.sv
// Shared types and default widths for the simulation run sequencer.
// Imported by the top level and the per-channel enable divider.
package sim_clk_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int unsigned DEF_DIV_W = 8;
  localparam int unsigned DEF_CNT_W = 32;

endpackage

// File: rtl/sim_clk_seq_clk_en_div.sv
// One clock-enable channel: captured divide value, phase counter, strobe and
// retire flag. The strobe is registered from the sequencer's next-state view.
module clk_en_div
  import sim_clk_seq_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             run_i,
  input  logic             drain_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             clk_en_o,
  output logic             retired_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] ph_q, ph_d;
  logic             en_q, en_d;
  logic             ret_q, ret_d;
  logic             hit_s;

  // Phase/strobe update; phase keeps its RUN cadence through DRAIN until the
  // next strobe, which also retires the channel.
  always_comb begin
    div_d = div_q;
    ph_d  = ph_q;
    ret_d = ret_q;
    en_d  = 1'b0;
    hit_s = (ph_q == div_q);
    if (load_i) begin
      div_d = div_i;
      ph_d  = '0;
      ret_d = 1'b0;
    end else if (run_i || (drain_i && !ret_q)) begin
      en_d  = hit_s;
      ph_d  = hit_s ? '0 : ph_q + DIV_W'(1);
      ret_d = drain_i & hit_s;
    end else begin
      en_d  = 1'b0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      ph_q  <= '0;
      en_q  <= 1'b0;
      ret_q <= 1'b0;
    end else begin
      div_q <= div_d;
      ph_q  <= ph_d;
      en_q  <= en_d;
      ret_q <= ret_d;
    end
  end

  assign clk_en_o  = en_q;
  assign retired_o = ret_q;

endmodule

// File: rtl/sim_clk_seq.sv
// Run sequencer: holds DUT reset for RST_CYCLES after start, runs N_EN divided
// enable strobes, counts RUN cycles and drains the channels before DONE.
module sim_clk_seq
  import sim_clk_seq_pkg::*;
#(
  parameter int N_EN       = 4,
  parameter int DIV_W      = DEF_DIV_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RST_CYCLES = 4,
  parameter int DEBUG      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop_req,
  input  logic [CNT_W-1:0]        max_cycles,
  input  logic [N_EN*DIV_W-1:0]   div,
  output logic                    dut_rst,
  output logic                    run,
  output logic [N_EN-1:0]         clk_en,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic                    done
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             dut_rst_q, run_q, done_q;
  logic             load_s, limit_s;
  logic             run_next_s, drain_next_s;
  logic [N_EN-1:0]  ret_s;

  // Next-state, countdown, cycle counter and capture logic.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    load_s  = 1'b0;
    limit_s = (max_q != '0) && (cnt_q == max_q - CNT_ONE);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RESET;
          load_s  = 1'b1;
          rc_d    = RC_LOAD;
          cnt_d   = '0;
          max_d   = max_cycles;
        end else begin
          state_d = state_q;
        end
      end
      RESET: begin
        if (stop_req) begin
          state_d = DONE;
        end else if (rc_q == '0) begin
          state_d = RUN;
        end else begin
          rc_d = rc_q - RC_W'(1);
        end
      end
      RUN: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
        if (stop_req || limit_s) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (&ret_s) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channels see the state of the cycle their strobe will be presented in.
  assign run_next_s   = (state_d == RUN);
  assign drain_next_s = (state_d == DRAIN);

  // Sequencer registers; outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rc_q      <= '0;
      cnt_q     <= '0;
      max_q     <= '0;
      dut_rst_q <= 1'b1;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rc_q      <= rc_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      dut_rst_q <= !(run_next_s || drain_next_s);
      run_q     <= run_next_s;
      done_q    <= (state_d == DONE);
    end
  end

  for (genvar g = 0; g < N_EN; g++) begin : g_ch
    clk_en_div #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk_i     (clk),
      .rst_i     (rst),
      .load_i    (load_s),
      .run_i     (run_next_s),
      .drain_i   (drain_next_s),
      .div_i     (div[g*DIV_W +: DIV_W]),
      .clk_en_o  (clk_en[g]),
      .retired_o (ret_s[g])
    );
  end

  assign dut_rst   = dut_rst_q;
  assign run       = run_q;
  assign done      = done_q;
  assign cycle_cnt = cnt_q;

  if (DEBUG != 0) begin : g_debug
    // Simulation-only transition trace.
    always @(posedge clk) begin
      if (!rst && (state_d != state_q)) begin
        $display("%0t sim_clk_seq %s -> %s", $time, state_q.name(), state_d.name());
      end
    end
  end

endmodule

// File: tb/tb_sim_clk_seq.sv
// Self-checking bench for sim_clk_seq: per-cycle comparison against a
// run-level arithmetic model of reset, run, drain and done phases.
module tb_sim_clk_seq;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 32;
  localparam int RC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start, stop_req;
  logic [CW-1:0]   max_cycles;
  logic [N*DW-1:0] div;
  logic            dut_rst, run, done;
  logic [N-1:0]    clk_en;
  logic [CW-1:0]   cycle_cnt;

  logic            start2, stop2;
  logic [3:0]      max2;
  logic [15:0]     div2;
  logic            dut_rst2, run2, done2;
  logic [1:0]      clk_en2;
  logic [3:0]      cnt2;

  int checks = 0;
  int errors = 0;
  int m_div[N];
  int m_max;

  sim_clk_seq #(.N_EN(N), .DIV_W(DW), .CNT_W(CW), .RST_CYCLES(RC), .DEBUG(0)) dut (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
    .max_cycles(max_cycles), .div(div), .dut_rst(dut_rst), .run(run),
    .clk_en(clk_en), .cycle_cnt(cycle_cnt), .done(done)
  );

  sim_clk_seq #(.N_EN(2), .DIV_W(8), .CNT_W(4), .RST_CYCLES(RC), .DEBUG(0)) dut_sat (
    .clk(clk), .rst(rst), .start(start2), .stop_req(stop2),
    .max_cycles(max2), .div(div2), .dut_rst(dut_rst2), .run(run2),
    .clk_en(clk_en2), .cycle_cnt(cnt2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dut_rst"}, 32'(dut_rst), 32'd1);
    chk({tag, "_run"}, 32'(run), 32'd0);
    chk({tag, "_clk_en"}, 32'(clk_en), 32'd0);
    chk({tag, "_cnt"}, cycle_cnt, 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic drive_cfg();
    for (int i = 0; i < N; i++) div[i*DW +: DW] = DW'(m_div[i]);
    max_cycles = CW'(m_max);
  endtask

  // abort_p>0: stop_req in RESET period abort_p. stop_j>0: stop_req in RUN cycle stop_j.
  task automatic run_check(input int abort_p, input int stop_j, input bit spam);
    int r_len, d_len, total, j, dd, ph;
    int d[N];
    logic [N-1:0] en_e;
    logic [31:0]  cnt_e;
    drive_cfg();
    stop_req = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    div = $urandom;
    max_cycles = $urandom;
    r_len = 0;
    d_len = 0;
    if (abort_p == 0) begin
      if (m_max != 0 && (stop_j == 0 || m_max < stop_j)) r_len = m_max;
      else r_len = stop_j;
      for (int i = 0; i < N; i++) begin
        d[i] = (m_div[i] + 1) - (r_len % (m_div[i] + 1));
        if (d[i] > d_len) d_len = d[i];
      end
    end
    total = (abort_p > 0) ? abort_p + 3 : RC + r_len + d_len + 3;
    for (int p = 1; p <= total; p++) begin
      j = 0;
      dd = 0;
      if (abort_p > 0 && p > abort_p) ph = 3;
      else if (p <= RC) ph = 0;
      else begin
        j = p - RC;
        if (j <= r_len) ph = 1;
        else begin
          dd = j - r_len;
          ph = (dd <= d_len) ? 2 : 3;
        end
      end
      en_e = '0;
      cnt_e = (ph == 0) ? 32'd0 : (ph == 1) ? 32'(j - 1) : 32'(r_len);
      for (int i = 0; i < N; i++) begin
        if (ph == 1) en_e[i] = ((j % (m_div[i] + 1)) == 0);
        if (ph == 2) en_e[i] = (dd == d[i]);
      end
      chk("dut_rst", 32'(dut_rst), 32'(ph == 0 || ph == 3));
      chk("run", 32'(run), 32'(ph == 1));
      chk("done", 32'(done), 32'(ph == 3));
      chk("clk_en", 32'(clk_en), 32'(en_e));
      chk("cycle_cnt", cycle_cnt, cnt_e);
      stop_req = (abort_p > 0 && p == abort_p) ||
                 (abort_p == 0 && ph == 1 && stop_j != 0 && j == stop_j) ||
                 (ph >= 2 && $urandom_range(0, 1) == 1);
      start = spam && (ph != 3) && ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    stop_req = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop_req = 1'b0; max_cycles = '0; div = '0;
    start2 = 1'b0; stop2 = 1'b0; max2 = 4'd0; div2 = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("idle");

    // Directed plan scenario: div {0,1,3,2}, max 10.
    m_div = '{0, 1, 3, 2};
    m_max = 10;
    run_check(0, 0, 1'b0);

    // Unlimited run ended by stop_req in RUN cycle 20.
    m_max = 0;
    run_check(0, 20, 1'b0);

    // stop_req during RESET aborts straight to DONE.
    m_max = 10;
    run_check(2, 0, 1'b0);

    // rst mid-RUN, then replay the directed scenario.
    drive_cfg();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (RC + 6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals("midrst");
    run_check(0, 0, 1'b0);

    // Start from DONE with channel 0 div 7 while start is spammed.
    m_div[0] = 7;
    for (int i = 1; i < N; i++) m_div[i] = $urandom_range(0, 6);
    m_max = $urandom_range(12, 25);
    run_check(0, 0, 1'b1);

    // Randomized runs.
    for (int k = 0; k < 6; k++) begin
      int mode, sj;
      for (int i = 0; i < N; i++) m_div[i] = $urandom_range(0, 9);
      mode = $urandom_range(0, 2);
      m_max = (mode == 1) ? 0 : $urandom_range(1, 30);
      sj = (mode == 0) ? 0 : $urandom_range(1, 30);
      run_check(0, sj, 1'($urandom_range(0, 1)));
    end

    // Narrow counter saturates at 15 while strobes continue.
    div2 = {8'd2, 8'd0};
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int p = 1; p <= RC + 24; p++) begin
      if (p > RC) begin
        int j;
        j = p - RC;
        chk("sat_run", 32'(run2), 32'd1);
        chk("sat_cnt", 32'(cnt2), 32'((j - 1 > 15) ? 15 : j - 1));
        chk("sat_clk_en", 32'(clk_en2), 32'({((j % 3) == 0), 1'b1}));
        stop2 = (j == 24);
      end
      @(posedge clk); #1;
    end
    stop2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sat_done", 32'(done2), 32'd1);
    chk("sat_dut_rst", 32'(dut_rst2), 32'd1);
    chk("sat_cnt_held", 32'(cnt2), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
